// File: rtl/spi_sclk_engine_if.sv
// Control/strobe bundle between the SPI control FSM (master side) and the SCLK engine (slave side).
interface spi_sclk_engine_if #(
  parameter int DIV_W = 8,
  parameter int CNT_W = 6
);
  logic             start;
  logic             abort;
  logic             cpol;
  logic             cpha;
  logic [DIV_W-1:0] div;
  logic [CNT_W-1:0] nbits;
  logic             sclk;
  logic             sample_stb;
  logic             shift_stb;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, cpol, cpha, div, nbits,
    input  sclk, sample_stb, shift_stb, busy, done
  );

  modport slave (
    input  start, abort, cpol, cpha, div, nbits,
    output sclk, sample_stb, shift_stb, busy, done
  );
endinterface

// File: rtl/spi_sclk_engine.sv
// SPI serial-clock engine: SCLK generation for all CPOL/CPHA modes, per-edge sample/shift strobes,
// busy/done framing. Define SPI_SCLK_GAP_EN to append GAP idle half-periods after each frame.
module spi_sclk_engine #(
  parameter int DIV_W    = 8,
  parameter int CNT_W    = 6,
  parameter bit CPOL_DEF = 1'b0,
  parameter int GAP      = 2
) (
  input logic               clk,
  input logic               reset,
  spi_sclk_engine_if.slave  bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_TAIL, ST_GAP} state_t;

  state_t           state, state_nxt;
  logic             cpol_q, cpha_q;
  logic [DIV_W-1:0] div_q, hc;
  logic [CNT_W-1:0] nbits_q;
  logic [CNT_W:0]   ec, ec_inc;
  logic             sclk_q;
  logic             accept, hp_end, last_edge;

  if (GAP < 1) begin : g_gap_check
    $error("spi_sclk_engine: GAP must be at least 1");
  end

  assign accept    = (state == ST_IDLE) && bus.start && !bus.abort;
  assign hp_end    = (hc == div_q);
  assign ec_inc    = ec + 1'b1;
  assign last_edge = (ec_inc == {nbits_q, 1'b0});
  assign bus.sclk  = sclk_q;

`ifdef SPI_SCLK_GAP_EN
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

  logic [GAP_W-1:0] gc;
  logic             gap_last;

  assign gap_last = hp_end && (gc == GAP_W'(GAP - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                gc <= '0;
    else if (state != ST_GAP) gc <= '0;
    else if (hp_end)          gc <= gc + 1'b1;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every comb block assigns its outputs a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = (bus.nbits == '0) ? ST_TAIL : ST_RUN;
      ST_RUN: begin
        if (bus.abort)                state_nxt = ST_IDLE;
        else if (hp_end && last_edge) state_nxt = ST_TAIL;
      end
      ST_TAIL: begin
        if (bus.abort)   state_nxt = ST_IDLE;
`ifdef SPI_SCLK_GAP_EN
        else if (hp_end) state_nxt = ST_GAP;
`else
        else if (hp_end) state_nxt = ST_IDLE;
`endif
      end
`ifdef SPI_SCLK_GAP_EN
      ST_GAP: if (bus.abort || gap_last) state_nxt = ST_IDLE;
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so all of them update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      div_q   <= '0;
      nbits_q <= '0;
      hc      <= '0;
      ec      <= '0;
      sclk_q  <= CPOL_DEF;
    end else begin
      if (accept) begin
        cpol_q  <= bus.cpol;
        cpha_q  <= bus.cpha;
        div_q   <= bus.div;
        nbits_q <= bus.nbits;
      end

      if (state == ST_IDLE || bus.abort || hp_end) hc <= '0;
      else                                         hc <= hc + 1'b1;

      if (state != ST_RUN || bus.abort) ec <= '0;
      else if (hp_end)                  ec <= ec_inc;

      // Idle tracks the live polarity so the line is already correct when a frame starts.
      if (state == ST_IDLE)                sclk_q <= bus.cpol;
      else if (bus.abort)                  sclk_q <= cpol_q;
      else if (state == ST_RUN && hp_end)  sclk_q <= ~sclk_q;
    end
  end

  always_comb begin
    bus.busy       = (state != ST_IDLE);
    bus.sample_stb = 1'b0;
    bus.shift_stb  = 1'b0;
    bus.done       = 1'b0;
    case (state)
      ST_RUN: begin
        // ec_inc is the number of the edge happening now; odd numbers are leading edges.
        if (hp_end && !bus.abort) begin
          if (cpha_q) begin
            bus.shift_stb  = ec_inc[0];
            bus.sample_stb = !ec_inc[0];
          end else begin
            bus.sample_stb = ec_inc[0];
            bus.shift_stb  = !ec_inc[0] && !last_edge;
          end
        end
      end
`ifdef SPI_SCLK_GAP_EN
      ST_GAP:  bus.done = gap_last && !bus.abort;
`else
      ST_TAIL: bus.done = hp_end && !bus.abort;
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_spi_sclk_engine.sv
// Self-checking bench for spi_sclk_engine: directed frames plus randomized traffic against a
// frame-offset arithmetic model. Honours SPI_SCLK_GAP_EN when defined.
module tb_spi_sclk_engine;
  localparam int DIV_W    = 8;
  localparam int CNT_W    = 6;
  localparam bit CPOL_DEF = 1'b0;
  localparam int GAP      = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  spi_sclk_engine_if #(.DIV_W(DIV_W), .CNT_W(CNT_W)) bus ();

  spi_sclk_engine #(.DIV_W(DIV_W), .CNT_W(CNT_W), .CPOL_DEF(CPOL_DEF), .GAP(GAP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: position inside the current frame plus the latched frame settings.
  bit m_busy = 1'b0;
  bit m_sclk = CPOL_DEF;
  int m_t, m_len;
  bit p_cpol, p_cpha;
  int p_div, p_n;

  // Observed per-frame tallies.
  int c_sample, c_shift, c_busy, c_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      if (n_err <= 25)
        $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic int frame_len(input int dv, input int nb);
    int len;
    len = (2 * nb + 1) * (dv + 1);
`ifdef SPI_SCLK_GAP_EN
    len += GAP * (dv + 1);
`endif
    return len;
  endfunction

  task automatic cycle(input bit st, input bit ab, input bit cp, input bit ph,
                       input int dv, input int nb);
    bit e_sclk, e_sample, e_shift, e_busy, e_done;
    int hp, edges, k;
    @(negedge clk);
    bus.start = st;
    bus.abort = ab;
    bus.cpol  = cp;
    bus.cpha  = ph;
    bus.div   = DIV_W'(dv);
    bus.nbits = CNT_W'(nb);
    #1;
    e_sample = 1'b0;
    e_shift  = 1'b0;
    e_done   = 1'b0;
    e_busy   = m_busy;
    if (m_busy) begin
      hp    = p_div + 1;
      edges = 2 * p_n;
      e_sclk = (m_t < edges * hp) ? (p_cpol ^ bit'((m_t / hp) % 2)) : p_cpol;
      k = (m_t + 1) / hp;
      if (((m_t + 1) % hp == 0) && k >= 1 && k <= edges && !ab) begin
        if (!p_cpha) begin
          e_sample = (k % 2 == 1);
          e_shift  = (k % 2 == 0) && (k != edges);
        end else begin
          e_shift  = (k % 2 == 1);
          e_sample = (k % 2 == 0);
        end
      end
      e_done = (m_t == m_len - 1) && !ab;
    end else begin
      e_sclk = m_sclk;
    end
    check("sclk",       bus.sclk,       e_sclk);
    check("sample_stb", bus.sample_stb, e_sample);
    check("shift_stb",  bus.shift_stb,  e_shift);
    check("busy",       bus.busy,       e_busy);
    check("done",       bus.done,       e_done);
    c_sample += int'(bus.sample_stb);
    c_shift  += int'(bus.shift_stb);
    c_busy   += int'(bus.busy);
    c_done   += int'(bus.done);
    // Model state across the coming clock edge.
    if (!m_busy) begin
      m_sclk = cp;
      if (st && !ab) begin
        m_busy = 1'b1;
        m_t    = 0;
        p_cpol = cp;
        p_cpha = ph;
        p_div  = dv;
        p_n    = nb;
        m_len  = frame_len(dv, nb);
      end
    end else if (ab || m_t == m_len - 1) begin
      m_busy = 1'b0;
      m_sclk = p_cpol;
    end else begin
      m_t++;
    end
  endtask

  // One frame: accept cycle, then busy cycles with optional abort / stray start at a frame offset.
  task automatic run_frame(input bit cp, input bit ph, input int dv, input int nb,
                           input int abort_at, input int start_at);
    int t;
    c_sample = 0;
    c_shift  = 0;
    c_busy   = 0;
    c_done   = 0;
    cycle(1'b1, 1'b0, cp, ph, dv, nb);
    t = 0;
    while (m_busy && t < 5000) begin
      cycle(t == start_at, t == abort_at, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 7), $urandom_range(0, 15));
      t++;
    end
  endtask

  task automatic idle_cycle(input bit cp);
    cycle(1'b0, 1'b0, cp, 1'b0, 0, 0);
  endtask

  initial begin
    bit st, ab;
    int dv, nb;

    reset     = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.cpol  = CPOL_DEF;
    bus.cpha  = 1'b0;
    bus.div   = '0;
    bus.nbits = '0;
    #3;
    check("rst_sclk",   bus.sclk,       CPOL_DEF);
    check("rst_busy",   bus.busy,       1'b0);
    check("rst_done",   bus.done,       1'b0);
    check("rst_sample", bus.sample_stb, 1'b0);
    check("rst_shift",  bus.shift_stb,  1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    idle_cycle(1'b0);

    // Mode 0, div=1, nbits=8.
    run_frame(1'b0, 1'b0, 1, 8, -1, -1);
    check("m0_samples", c_sample, 8);
    check("m0_shifts",  c_shift,  7);
    check("m0_busy",    c_busy,   frame_len(1, 8));
    check("m0_done",    c_done,   1);

    // Mode 3, div=0, nbits=4; idle at 1 beforehand.
    idle_cycle(1'b1);
    idle_cycle(1'b1);
    run_frame(1'b1, 1'b1, 0, 4, -1, -1);
    check("m3_samples", c_sample, 4);
    check("m3_shifts",  c_shift,  4);
    check("m3_busy",    c_busy,   frame_len(0, 4));

    // Abort in the 5th edge cycle (offset 5*4-1) of a div=3, nbits=8 frame.
    idle_cycle(1'b0);
    run_frame(1'b0, 1'b0, 3, 8, 19, -1);
    check("ab_done",    c_done,   0);
    check("ab_busy",    c_busy,   20);
    check("ab_samples", c_sample, 2);
    check("ab_shifts",  c_shift,  2);
    idle_cycle(1'b0);
    run_frame(1'b0, 1'b0, 3, 8, -1, -1);
    check("re_samples", c_sample, 8);
    check("re_shifts",  c_shift,  7);
    check("re_done",    c_done,   1);

    // Stray start mid-frame, then start+abort together in idle.
    idle_cycle(1'b0);
    run_frame(1'b0, 1'b0, 1, 3, -1, 3);
    check("ss_samples", c_sample, 3);
    check("ss_shifts",  c_shift,  2);
    check("ss_busy",    c_busy,   frame_len(1, 3));
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1, 3);
    idle_cycle(1'b0);
    check("sa_dropped", bus.busy, 1'b0);

    // nbits=0 runs the tail only.
    run_frame(1'b0, 1'b0, 2, 0, -1, -1);
    check("n0_busy",    c_busy,   frame_len(2, 0));
    check("n0_done",    c_done,   1);
    check("n0_samples", c_sample, 0);

`ifdef SPI_SCLK_GAP_EN
    idle_cycle(1'b1);
    run_frame(1'b1, 1'b0, 1, 2, -1, -1);
    check("gap_busy", c_busy, 14);
    check("gap_done", c_done, 1);
`endif

    // Asynchronous reset in the middle of a div=2, nbits=8 frame.
    idle_cycle(1'b1);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 2, 8);
    for (int i = 0; i < 7; i++) idle_cycle(1'b1);
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.cpol  = CPOL_DEF;
    #2;
    reset = 1'b1;
    #1;
    check("mr_sclk",   bus.sclk,       CPOL_DEF);
    check("mr_busy",   bus.busy,       1'b0);
    check("mr_done",   bus.done,       1'b0);
    check("mr_sample", bus.sample_stb, 1'b0);
    check("mr_shift",  bus.shift_stb,  1'b0);
    m_busy = 1'b0;
    m_sclk = CPOL_DEF;
    @(negedge clk);
    reset = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      if (!m_busy) begin
        st = ($urandom_range(0, 2) == 0);
        ab = ($urandom_range(0, 7) == 0);
      end else begin
        st = ($urandom_range(0, 15) == 0);
        ab = ($urandom_range(0, 79) == 0);
      end
      dv = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 3);
      nb = ($urandom_range(0, 29) == 0) ? 63 : $urandom_range(0, 10);
      cycle(st, ab, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), dv, nb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
